// File: rtl/plot_cell_pkg.sv
// Shared constants, cell-address helper and FSM state type for the plot-stream cell reader.
package plot_cell_pkg;

  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;
  localparam int CELL    = 10;
  localparam int NCX     = 16;
  localparam int NCY     = 12;
  localparam int NCELLS  = NCX * NCY;
  localparam int ADDR_W  = 8;

  localparam logic [2:0] APPLE_COLOUR = 3'b100;
  localparam logic [2:0] BG_COLOUR    = 3'b000;

  typedef logic [ADDR_W-1:0] cell_addr_t;

  typedef enum logic {SWEEP, RUN} state_t;

  // Row-major cell index: cy*NCX + cx.
  function automatic cell_addr_t cell_addr(input logic [3:0] cx, input logic [3:0] cy);
    return cell_addr_t'(cy) * cell_addr_t'(NCX) + cell_addr_t'(cx);
  endfunction

endpackage

// File: rtl/pix_to_cell.sv
// Combinational pixel-to-cell conversion (x/CELL, y/CELL) using threshold compare chains.
module pix_to_cell
  import plot_cell_pkg::*;
(
  input  logic [7:0] x,
  input  logic [6:0] y,
  output logic [3:0] cx,
  output logic [3:0] cy,
  output logic       in_range
);

  // Each threshold crossed bumps the quotient; no divider required.
  always_comb begin
    cx = '0;
    cy = '0;
    for (int i = 1; i < NCX; i++) begin
      if (int'(x) >= i * CELL) cx = 4'(i);
    end
    for (int j = 1; j < NCY; j++) begin
      if (int'(y) >= j * CELL) cy = 4'(j);
    end
    in_range = (int'(x) < XSCREEN) && (int'(y) < YSCREEN);
  end

endmodule

// File: rtl/plot_stream_cell_reader.sv
// Shadow cell map of the pixel-plot stream with pipelined cell queries.
// Optional macro PLOT_FORWARD_EN: bypass pending writes to queries instead of stalling q_ready.
module plot_stream_cell_reader
  import plot_cell_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       Resetn,
  input  logic       plot,
  input  logic [7:0] x,
  input  logic [6:0] y,
  input  logic [2:0] colour,
  input  logic       clear,
  input  logic       q_valid,
  input  logic [3:0] q_cx,
  input  logic [3:0] q_cy,
  output logic       q_ready,
  output logic       r_valid,
  output logic [2:0] r_colour,
  output logic       r_hit_apple,
  output logic       r_hit_body,
  output logic       r_offscreen,
  output logic       busy
);

  state_t     state, next_state;
  cell_addr_t sweep_addr;
  logic       sweep_last;
  logic       go_sweep;

  logic [3:0] pix_cx, pix_cy;
  logic       pix_in_range;
  logic       plot_take;

  logic       s1_valid, s2_valid;
  cell_addr_t s1_addr, s2_addr;
  logic [2:0] s1_colour, s2_colour;

  logic       q_accept, q_in_range;
  logic       qa_valid, qa_off;
  cell_addr_t qa_addr;
  logic [2:0] rd_colour;

  logic [2:0] cell_map [NCELLS];

  pix_to_cell u_pix_to_cell (
    .x        (x),
    .y        (y),
    .cx       (pix_cx),
    .cy       (pix_cy),
    .in_range (pix_in_range)
  );

  assign sweep_last = (sweep_addr == cell_addr_t'(NCELLS - 1));
  assign go_sweep   = (next_state == SWEEP);
  assign plot_take  = plot && pix_in_range && (state == RUN);
  assign q_accept   = q_valid && q_ready;
  assign q_in_range = (int'(q_cx) < NCX) && (int'(q_cy) < NCY);

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) state <= SWEEP;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      SWEEP: if (!clear && sweep_last) next_state = RUN;
      RUN:   if (clear)                next_state = SWEEP;
    endcase
  end

  // Without bypass, a query must wait until no write (incoming or pending) can be missed by the map read.
  always_comb begin
    busy    = (state == SWEEP);
    q_ready = 1'b0;
    if (state == RUN) begin
`ifdef PLOT_FORWARD_EN
      q_ready = 1'b1;
`else
      q_ready = !plot_take && !s1_valid && !s2_valid;
`endif
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn || clear || state == RUN || sweep_last) sweep_addr <= '0;
    else                                                sweep_addr <= sweep_addr + 8'd1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= plot_take && !go_sweep;
      s2_valid <= s1_valid && !go_sweep;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    s1_addr   <= cell_addr(pix_cx, pix_cy);
    s1_colour <= colour;
    s2_addr   <= s1_addr;
    s2_colour <= s1_colour;
  end

  always_ff @(posedge CLOCK_50) begin
    if (state == SWEEP)   cell_map[sweep_addr] <= BG_COLOUR;
    else if (s2_valid)    cell_map[s2_addr]    <= s2_colour;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) qa_valid <= 1'b0;
    else         qa_valid <= q_accept;
  end

  always_ff @(posedge CLOCK_50) begin
    if (q_accept) begin
      qa_off  <= !q_in_range;
      qa_addr <= q_in_range ? cell_addr(q_cx, q_cy) : '0;
    end
  end

  // Stage 1 holds the newest plot, so it overrides stage 2, which overrides the array.
  always_comb begin
    rd_colour = cell_map[qa_addr];
`ifdef PLOT_FORWARD_EN
    if (s2_valid && s2_addr == qa_addr) rd_colour = s2_colour;
    if (s1_valid && s1_addr == qa_addr) rd_colour = s1_colour;
`endif
    if (qa_off) rd_colour = BG_COLOUR;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      r_valid     <= 1'b0;
      r_colour    <= BG_COLOUR;
      r_hit_apple <= 1'b0;
      r_hit_body  <= 1'b0;
      r_offscreen <= 1'b0;
    end else begin
      r_valid <= qa_valid;
      if (qa_valid) begin
        r_colour    <= rd_colour;
        r_hit_apple <= (rd_colour == APPLE_COLOUR);
        r_hit_body  <= (rd_colour != BG_COLOUR) && (rd_colour != APPLE_COLOUR);
        r_offscreen <= qa_off;
      end
    end
  end

endmodule

// File: tb/tb_plot_stream_cell_reader.sv
// Scoreboard bench for plot_stream_cell_reader: directed plots/queries with hand-computed expectations.
module tb_plot_stream_cell_reader;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn   = 1'b0;
  logic       plot     = 1'b0;
  logic [7:0] x        = '0;
  logic [6:0] y        = '0;
  logic [2:0] colour   = '0;
  logic       clear    = 1'b0;
  logic       q_valid  = 1'b0;
  logic [3:0] q_cx     = '0;
  logic [3:0] q_cy     = '0;
  logic       q_ready, r_valid, r_hit_apple, r_hit_body, r_offscreen, busy;
  logic [2:0] r_colour;

  int cyc    = 0;
  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [2:0] colour;
    logic       off;
    int         due;
  } exp_t;

  exp_t sb[$];

  plot_stream_cell_reader dut (
    .CLOCK_50    (CLOCK_50),
    .Resetn      (Resetn),
    .plot        (plot),
    .x           (x),
    .y           (y),
    .colour      (colour),
    .clear       (clear),
    .q_valid     (q_valid),
    .q_cx        (q_cx),
    .q_cy        (q_cy),
    .q_ready     (q_ready),
    .r_valid     (r_valid),
    .r_colour    (r_colour),
    .r_hit_apple (r_hit_apple),
    .r_hit_body  (r_hit_body),
    .r_offscreen (r_offscreen),
    .busy        (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_miss++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: every response is matched against the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    if (r_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("[TB] FAIL unexpected_r_valid: got r_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_output("r_latency",     cyc,               e.due);
        check_output("r_colour",      int'(r_colour),    int'(e.colour));
        check_output("r_offscreen",   int'(r_offscreen), int'(e.off));
        check_output("r_hit_apple",   int'(r_hit_apple), int'(!e.off && e.colour == 3'b100));
        check_output("r_hit_body",    int'(r_hit_body),
                     int'(!e.off && e.colour != 3'b000 && e.colour != 3'b100));
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got time %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic sync_edge();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic plot_pixel(input int px, input int py, input int pcol);
    plot   = 1'b1;
    x      = 8'(px);
    y      = 7'(py);
    colour = 3'(pcol);
    sync_edge();
    plot = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    sync_edge();
    clear = 1'b0;
  endtask

  // Leaves q_valid high so successive calls present back-to-back queries.
  task automatic issue_query(input int cx, input int cy, input int exp_col, input int exp_off);
    bit   accepted;
    exp_t e;
    accepted = 1'b0;
    q_valid  = 1'b1;
    q_cx     = 4'(cx);
    q_cy     = 4'(cy);
    for (int i = 0; i < 64 && !accepted; i++) begin
      @(negedge CLOCK_50);
      if (q_ready) begin
        accepted = 1'b1;
        e.colour = 3'(exp_col);
        e.off    = exp_off[0];
        e.due    = cyc + 2;
        sb.push_back(e);
      end
      sync_edge();
      plot = 1'b0;
    end
    if (!accepted) check_output("q_ready_timeout", 0, 1);
  endtask

  task automatic end_queries();
    q_valid = 1'b0;
  endtask

  task automatic apply_stimulus_wait(input int n);
    repeat (n) sync_edge();
  endtask

  // Counts busy cycles; optionally injects a plot at (0,0) during the sweep.
  task automatic count_busy(input int plot_at, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLOCK_50);
      plot = 1'b0;
      if (!busy) break;
      n++;
      if (n == plot_at) begin
        plot   = 1'b1;
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'b011;
      end
    end
  endtask

  initial begin
    int n;

    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_output("reset_q_ready",     int'(q_ready),     0);
    check_output("reset_r_valid",     int'(r_valid),     0);
    check_output("reset_r_colour",    int'(r_colour),    0);
    check_output("reset_r_hit_apple", int'(r_hit_apple), 0);
    check_output("reset_r_hit_body",  int'(r_hit_body),  0);
    check_output("reset_r_offscreen", int'(r_offscreen), 0);
    check_output("reset_busy",        int'(busy),        1);
    sync_edge();
    Resetn = 1'b1;

    count_busy(-1, n);
    check_output("busy_cycles_after_reset", n, 192);
    sync_edge();
    issue_query(3, 4, 3'b000, 0);
    end_queries();

    for (int i = 0; i < 10; i++)
      for (int j = 0; j < 10; j++)
        plot_pixel(30 + i, 30 + j, 3'b100);
    issue_query(3, 3, 3'b100, 0);
    end_queries();
    apply_stimulus_wait(4);
    check_output("hold_r_colour",    int'(r_colour),    4);
    check_output("hold_r_hit_apple", int'(r_hit_apple), 1);

    plot   = 1'b1;
    x      = 8'd80;
    y      = 7'd60;
    colour = 3'b010;
    issue_query(8, 6, 3'b010, 0);
    end_queries();

    issue_query(2, 12, 3'b000, 1);
    issue_query(15, 12, 3'b000, 1);
    issue_query(3, 15, 3'b000, 1);
    end_queries();
    plot_pixel(165, 10, 3'b010);
    plot_pixel(10, 125, 3'b011);
    plot_pixel(159, 119, 3'b001);
    issue_query(0, 1, 3'b000, 0);
    issue_query(15, 1, 3'b000, 0);
    issue_query(1, 11, 3'b000, 0);
    issue_query(15, 11, 3'b001, 0);
    end_queries();

    plot_pixel(55, 55, 3'b010);
    issue_query(5, 5, 3'b010, 0);
    end_queries();
    apply_stimulus_wait(3);
    plot_pixel(22, 33, 3'b111);
    clear  = 1'b1;
    plot   = 1'b1;
    x      = 8'd0;
    y      = 7'd0;
    colour = 3'b011;
    sync_edge();
    clear = 1'b0;
    plot  = 1'b0;
    count_busy(-1, n);
    check_output("busy_cycles_after_clear", n, 192);
    sync_edge();

    pulse_clear();
    apply_stimulus_wait(30);
    pulse_clear();
    count_busy(30, n);
    check_output("busy_cycles_after_restart", n, 192);
    sync_edge();
    issue_query(5, 5, 3'b000, 0);
    issue_query(2, 3, 3'b000, 0);
    issue_query(0, 0, 3'b000, 0);
    end_queries();

    plot_pixel(5, 5, 3'b001);
    plot_pixel(15, 5, 3'b100);
    plot_pixel(25, 5, 3'b111);
    issue_query(0, 0, 3'b001, 0);
    issue_query(1, 0, 3'b100, 0);
    issue_query(2, 0, 3'b111, 0);
    end_queries();
    apply_stimulus_wait(4);
    check_output("hold_r_colour_body", int'(r_colour),   7);
    check_output("hold_r_hit_body",    int'(r_hit_body), 1);

    begin
      bit accepted;
      accepted = 1'b0;
      q_valid  = 1'b1;
      q_cx     = 4'd0;
      q_cy     = 4'd0;
      for (int i = 0; i < 64 && !accepted; i++) begin
        @(negedge CLOCK_50);
        accepted = q_ready;
        sync_edge();
      end
      if (!accepted) check_output("q_ready_timeout_reset_query", 0, 1);
      q_valid = 1'b0;
      Resetn  = 1'b0;
      repeat (2) @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      check_output("midreset_r_valid",  int'(r_valid),  0);
      check_output("midreset_r_colour", int'(r_colour), 0);
      check_output("midreset_q_ready",  int'(q_ready),  0);
      check_output("midreset_busy",     int'(busy),     1);
      sync_edge();
      Resetn = 1'b1;
    end
    count_busy(-1, n);
    check_output("busy_cycles_after_second_reset", n, 192);
    sync_edge();
    issue_query(0, 0, 3'b000, 0);
    end_queries();
    apply_stimulus_wait(5);

    check_output("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
